kernel_ops_multi: RTL and testbench

Parametrised N-channel 3x3 neighbourhood convolution engine for the image pipeline. Each accepted request carries one centre-pixel index per channel. The block fetches the 9 neighbourhood pixels per channel from that channel's frame-memory read port and applies a runtime-selected kernel. It returns one clamped result per channel through a valid/ready output. All channels run in lockstep, so a split frame (e.g. two half-images) is processed in parallel.

---
 rtl/kernel_ops_pkg.sv | 65 ++++++
 rtl/kernel_lane.sv | 119 +++++++++++
 rtl/kernel_ops_multi.sv | 103 ++++++++++
 tb/tb_kernel_ops_multi.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_ops_pkg.sv
// kernel_ops_pkg: mode/state encodings, tap offsets and 3x3 coefficients
// shared by kernel_ops_multi and kernel_lane.
package kernel_ops_pkg;

  localparam logic [1:0] MODE_ID    = 2'b00;
  localparam logic [1:0] MODE_GAUSS = 2'b01;
  localparam logic [1:0] MODE_SHARP = 2'b10;
  localparam logic [1:0] MODE_LAPL  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_SAT   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int LAST_TAP    = 8;
  localparam int GAUSS_SHIFT = 4;
  localparam int GAUSS_ROUND = 8;

  function automatic int tap_dr(input logic [3:0] t);
    int d;
    if (t < 4'd3) d = -1;
    else if (t < 4'd6) d = 0;
    else d = 1;
    return d;
  endfunction

  function automatic int tap_dc(input logic [3:0] t);
    return int'(t) - 3 * (tap_dr(t) + 1) - 1;
  endfunction

  function automatic logic signed [4:0] kcoef(
    input logic [1:0] m,
    input logic [3:0] t
  );
    logic signed [4:0] k;
    logic edge_tap;
    logic corner;
    edge_tap = (t == 4'd1) || (t == 4'd3) ||
               (t == 4'd5) || (t == 4'd7);
    corner = (t == 4'd0) || (t == 4'd2) ||
             (t == 4'd6) || (t == 4'd8);
    k = '0;
    unique case (m)
      MODE_ID: begin
        if (t == 4'd4) k = 5'sd1;
      end
      MODE_GAUSS: begin
        if (t == 4'd4) k = 5'sd4;
        else if (edge_tap) k = 5'sd2;
        else if (corner) k = 5'sd1;
      end
      MODE_SHARP: begin
        if (t == 4'd4) k = 5'sd5;
        else if (edge_tap) k = -5'sd1;
      end
      default: begin
        if (t == 4'd4) k = 5'sd8;
        else k = -5'sd1;
      end
    endcase
    return k;
  endfunction

endpackage

// File: rtl/kernel_lane.sv
// kernel_lane: one channel's address gen, border flag, MAC and clamp.
// BORDER_REPLICATE_EN: out-of-image taps use clamped-coordinate data.
module kernel_lane
  import kernel_ops_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 13,
  parameter int ADDR_W = 12,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pix_in,
  input  logic [1:0]        mode,
  input  logic              addr_en,
  input  logic [3:0]        addr_tap,
  input  logic              acc_en,
  input  logic [3:0]        acc_tap,
  input  logic              sat_en,
  input  logic [DATA_W-1:0] t_data,
  output logic [ADDR_W-1:0] t_address,
  output logic [DATA_W-1:0] result
);

  localparam int LW = $clog2(IMG_W);

`ifdef BORDER_REPLICATE_EN
  localparam logic REPL = 1'b1;
`else
  localparam logic REPL = 1'b0;
`endif

  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'(GAUSS_ROUND);
  localparam logic signed [ACC_W-1:0] MAXV =
    ACC_W'((1 << DATA_W) - 1);

  function automatic logic tap_in(
    input logic [ADDR_W-1:0] ctr,
    input logic [3:0]        t
  );
    int r;
    int c;
    r = int'(ctr[ADDR_W-1:LW]) + tap_dr(t);
    c = int'(ctr[LW-1:0]) + tap_dc(t);
    return (r >= 0) && (r < IMG_H) &&
           (c >= 0) && (c < IMG_W);
  endfunction

  function automatic logic [ADDR_W-1:0] tap_addr(
    input logic [ADDR_W-1:0] ctr,
    input logic [3:0]        t
  );
    int r;
    int c;
    r = int'(ctr[ADDR_W-1:LW]) + tap_dr(t);
    c = int'(ctr[LW-1:0]) + tap_dc(t);
    if (r < 0) r = 0;
    if (r > IMG_H - 1) r = IMG_H - 1;
    if (c < 0) c = 0;
    if (c > IMG_W - 1) c = IMG_W - 1;
    return ADDR_W'(r * IMG_W + c);
  endfunction

  logic [ADDR_W-1:0]        centre;
  logic [ADDR_W-1:0]        nxt_addr;
  logic                     oor;
  logic                     keep;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  coef_x;
  logic signed [ACC_W-1:0]  pix_x;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  shaped;
  logic [DATA_W-1:0]        clamped;

  assign nxt_addr = tap_addr(start ? pix_in : centre,
                             start ? 4'd0 : addr_tap);
  assign oor = int'(centre[ADDR_W-1:LW]) >= IMG_H;
  assign keep = !oor && (REPL || tap_in(centre, acc_tap));
  assign coef_x = ACC_W'(kcoef(mode, acc_tap));
  assign pix_x = ACC_W'($signed({1'b0, t_data}));
  assign prod = coef_x * pix_x;

  // Post-scale the sum per mode, then saturate to the pixel range.
  always_comb begin
    shaped = acc;
    unique case (mode)
      MODE_GAUSS: shaped = (acc + RND) >>> GAUSS_SHIFT;
      MODE_LAPL:  shaped = (acc < 0) ? -acc : acc;
      default:    shaped = acc;
    endcase
    clamped = '0;
    if (oor || shaped < 0) clamped = '0;
    else if (shaped > MAXV) clamped = '1;
    else clamped = shaped[DATA_W-1:0];
  end

  // Latch centre, step the read address, accumulate, register result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      centre    <= '0;
      t_address <= '0;
      acc       <= '0;
      result    <= '0;
    end else begin
      if (start) begin
        centre <= pix_in;
        acc    <= '0;
      end else if (acc_en && keep) begin
        acc <= acc + prod;
      end
      if (start || addr_en) t_address <= nxt_addr;
      if (sat_en) result <= clamped;
    end
  end

endmodule

// File: rtl/kernel_ops_multi.sv
// kernel_ops_multi: N-channel lockstep 3x3 convolution, shared FSM.
// BORDER_REPLICATE_EN selects edge replication instead of zero padding.
module kernel_ops_multi
  import kernel_ops_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 13,
  parameter int ADDR_W = 12,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [NUM_CH*ADDR_W-1:0] pixel,
  output logic [NUM_CH*ADDR_W-1:0] t_address,
  input  logic [NUM_CH*DATA_W-1:0] t_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] output_result
);

  logic [2:0] state;
  logic [3:0] tap;
  logic [1:0] mode_q;
  logic       start;
  logic       addr_en;
  logic       acc_en;
  logic       sat_en;
  logic [3:0] addr_tap;
  logic [3:0] acc_tap;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign start     = in_ready && in_valid;
  assign addr_en   = (state == ST_FETCH) &&
                     (tap != 4'(LAST_TAP));
  assign addr_tap  = tap + 4'd1;
  assign acc_en    = ((state == ST_FETCH) && (tap != 4'd0)) ||
                     (state == ST_DRAIN);
  assign acc_tap   = (state == ST_DRAIN) ? 4'(LAST_TAP)
                                         : tap - 4'd1;
  assign sat_en    = (state == ST_SAT);

  // Sequence one request: fetch 9 taps, drain, saturate, hand off.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= ST_IDLE;
      tap    <= '0;
      mode_q <= MODE_ID;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mode_q <= mode;
            tap    <= '0;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (tap == 4'(LAST_TAP)) begin
            tap   <= '0;
            state <= ST_DRAIN;
          end else begin
            tap <= tap + 4'd1;
          end
        end
        ST_DRAIN: state <= ST_SAT;
        ST_SAT:   state <= ST_DONE;
        ST_DONE:  if (out_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    kernel_lane #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .pix_in    (pixel[g*ADDR_W +: ADDR_W]),
      .mode      (mode_q),
      .addr_en   (addr_en),
      .addr_tap  (addr_tap),
      .acc_en    (acc_en),
      .acc_tap   (acc_tap),
      .sat_en    (sat_en),
      .t_data    (t_data[g*DATA_W +: DATA_W]),
      .t_address (t_address[g*ADDR_W +: ADDR_W]),
      .result    (output_result[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_kernel_ops_multi.sv
// tb_kernel_ops_multi: directed + random requests vs a 3x3 reference
// model over per-channel frame memories.
module tb_kernel_ops_multi;

  localparam int NUM_CH = 2;
  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int DATA_W = 13;
  localparam int ADDR_W = 12;
  localparam int ACC_W  = 20;
  localparam int MAXV   = (1 << DATA_W) - 1;

  logic                     clk;
  logic                     n_rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               mode;
  logic [NUM_CH*ADDR_W-1:0] pixel;
  logic [NUM_CH*ADDR_W-1:0] t_address;
  logic [NUM_CH*DATA_W-1:0] t_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH*DATA_W-1:0] output_result;

  logic [DATA_W-1:0] mem [NUM_CH][1 << ADDR_W];
  logic [DATA_W-1:0] td  [NUM_CH];

  int n_chk  = 0;
  int n_pass = 0;

  int kt [4][9] = '{
    '{ 0,  0,  0,  0, 1,  0,  0,  0,  0},
    '{ 1,  2,  1,  2, 4,  2,  1,  2,  1},
    '{ 0, -1,  0, -1, 5, -1,  0, -1,  0},
    '{-1, -1, -1, -1, 8, -1, -1, -1, -1}
  };

  kernel_ops_multi #(
    .NUM_CH (NUM_CH),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mode          (mode),
    .pixel         (pixel),
    .t_address     (t_address),
    .t_data        (t_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .output_result (output_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mem
    always @(posedge clk)
      td[g] <= mem[g][t_address[g*ADDR_W +: ADDR_W]];
    assign t_data[g*DATA_W +: DATA_W] = td[g];
  end

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model(input int ch, input int md,
                               input int idx);
    int r, c, rr, cc, acc, v;
    bit ins;
    r = idx / IMG_W;
    c = idx % IMG_W;
    acc = 0;
    if (r >= IMG_H) return 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        ins = rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W;
        rr = rr < 0 ? 0 : (rr >= IMG_H ? IMG_H - 1 : rr);
        cc = cc < 0 ? 0 : (cc >= IMG_W ? IMG_W - 1 : cc);
        v = int'(mem[ch][rr * IMG_W + cc]);
`ifdef BORDER_REPLICATE_EN
        ins = 1'b1;
`endif
        if (ins) acc += kt[md][(dr + 1) * 3 + dc + 1] * v;
      end
    end
    if (md == 1) acc = (acc + 8) >>> 4;
    if (md == 3 && acc < 0) acc = -acc;
    if (acc < 0) acc = 0;
    if (acc > MAXV) acc = MAXV;
    return acc;
  endfunction

  task automatic fill(input int ch, input int v);
    for (int a = 0; a < (1 << ADDR_W); a++)
      mem[ch][a] = DATA_W'(v);
  endtask

  task automatic fill_lin();
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int a = 0; a < (1 << ADDR_W); a++)
        mem[ch][a] = DATA_W'(a);
  endtask

  task automatic fill_rand();
    int big;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      big = $urandom_range(0, 1);
      for (int a = 0; a < (1 << ADDR_W); a++)
        mem[ch][a] = DATA_W'(big != 0 ? $urandom_range(0, MAXV)
                                       : $urandom_range(0, 300));
    end
  endtask

  task automatic run(input int md, input int p0, input int p1,
                     input int e0, input int e1, input int stall);
    int x0, x1, n;
    int held;
    x0 = (e0 < 0) ? model(0, md, p0) : e0;
    x1 = (e1 < 0) ? model(1, md, p1) : e1;
    @(negedge clk);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    mode = 2'(md);
    pixel = {ADDR_W'(p1), ADDR_W'(p0)};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode = ~mode;
    pixel = ~pixel;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("latency", n, 11);
    check("res_ch0", int'(output_result[DATA_W-1:0]), x0);
    check("res_ch1", int'(output_result[2*DATA_W-1:DATA_W]), x1);
    held = int'(output_result);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_ready", int'(in_ready), 0);
      check("hold_result", int'(output_result), held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", int'(out_valid), 0);
    check("post_hs_ready", int'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int md, r0, c0, r1, c1, e_g, e_s;
    n_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = '0;
    pixel = '0;
    fill_lin();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_t_address", int'(t_address), 0);
    check("rst_result", int'(output_result), 0);
    @(negedge clk);
    n_rst = 1'b1;

    run(0, 65, 2048 + 65, 65, 2113, 0);

    fill(0, 100);
    fill(1, 100);
    run(1, 130, 130, 100, 100, 2);
`ifdef BORDER_REPLICATE_EN
    e_g = 100;
    e_s = 100;
`else
    e_g = 56;
    e_s = 300;
`endif
    run(1, 0, 0, e_g, e_g, 0);
    run(2, 0, 0, e_s, e_s, 5);

    fill(0, 500);
    fill(1, 500);
    mem[0][130] = '0;
    mem[1][130] = '0;
    run(2, 130, 130, 0, 0, 0);

    fill(0, 0);
    fill(1, 0);
    mem[0][130] = 13'd1000;
    mem[1][130] = 13'd1000;
    run(3, 130, 130, 8000, 8000, 0);
    mem[0][130] = 13'd8191;
    mem[1][130] = 13'd8191;
    run(3, 130, 130, 8191, 8191, 1);

    fill_lin();
    @(negedge clk);
    in_valid = 1'b1;
    mode = 2'd1;
    pixel = {ADDR_W'(700), ADDR_W'(300)};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_t_address", int'(t_address), 0);
    check("abort_result", int'(output_result), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", int'(in_ready), 1);
    check("rel_out_valid", int'(out_valid), 0);
    run(0, 65, 2048 + 65, 65, 2113, 0);

    for (int it = 0; it < 40; it++) begin
      if (it % 10 == 0) fill_rand();
      md = $urandom_range(0, 3);
      r0 = $urandom_range(0, IMG_H - 1);
      c0 = $urandom_range(0, IMG_W - 1);
      r1 = $urandom_range(0, IMG_H - 1);
      c1 = $urandom_range(0, IMG_W - 1);
      if ($urandom_range(0, 3) == 0)
        r0 = ($urandom_range(0, 1) != 0) ? 0 : IMG_H - 1;
      if ($urandom_range(0, 3) == 0)
        c0 = ($urandom_range(0, 1) != 0) ? 0 : IMG_W - 1;
      if ($urandom_range(0, 3) == 0)
        c1 = ($urandom_range(0, 1) != 0) ? 0 : IMG_W - 1;
      run(md, r0 * IMG_W + c0, r1 * IMG_W + c1, -1, -1,
          $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
